pixel_frame_scheduler: RTL and testbench

Frame-level scheduler between the pixel downscaler output and the pixel AXI4 master TX. It tracks the downscaled raster (COL_NUM/2 × ROW_NUM/2), decides per frame whether to forward, drop (frame-rate decimation) or idle, and supports single-shot capture. It tags forwarded pixels with line-last and frame-last markers. It never stalls the camera pipeline except through real downstream back-pressure during a forwarded frame.

---
 rtl/pixel_frame_scheduler_if.sv | 40 ++++
 rtl/pixel_frame_scheduler.sv | 173 +++++++++++++++++
 tb/tb_pixel_frame_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_scheduler_if.sv
// Pixel stream bundle between the downscaler, the frame scheduler and the AXI master.
//   pds_* : downscaled pixel stream into the scheduler (valid/ready)
//   pat_* : tagged pixel stream out to the AXI master (valid/ready + line/frame last)
// Modports:
//   slave  : the scheduler's view (consumes pds_*, produces pat_*)
//   master : the surrounding environment's view (produces pds_*, consumes pat_*)
interface pixel_frame_scheduler_if #(
    parameter int unsigned GS_PXL_W = 8
) ();
    logic [GS_PXL_W-1:0] pds_pxl;
    logic                pds_pxl_vld;
    logic                pds_pxl_rdy;
    logic [GS_PXL_W-1:0] pat_pxl;
    logic                pat_pxl_vld;
    logic                pat_pxl_rdy;
    logic                pat_line_last;
    logic                pat_frame_last;

    modport slave (
        input  pds_pxl,
        input  pds_pxl_vld,
        output pds_pxl_rdy,
        output pat_pxl,
        output pat_pxl_vld,
        input  pat_pxl_rdy,
        output pat_line_last,
        output pat_frame_last
    );

    modport master (
        output pds_pxl,
        output pds_pxl_vld,
        input  pds_pxl_rdy,
        input  pat_pxl,
        input  pat_pxl_vld,
        output pat_pxl_rdy,
        input  pat_line_last,
        input  pat_frame_last
    );
endinterface

// File: rtl/pixel_frame_scheduler.sv
// Frame-level scheduler between the pixel downscaler and the pixel AXI4 master.
// Tracks the downscaled raster (COL_NUM/2 x ROW_NUM/2) and decides per frame whether to
// forward it (STREAM), drop it for frame-rate decimation (DROP) or discard it (IDLE/DONE).
// Forwarded pixels pass through combinationally, tagged with line-last / frame-last.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   cfg_en_i       : capture enable (level)
//   cfg_single_i   : 1 = single-shot, 0 = continuous
//   cfg_skip_i     : frames dropped between forwarded frames
//   bus            : pixel_frame_scheduler_if.slave (pds_* in, pat_* out)
//   busy_o         : high while streaming a frame
//   done_o         : one-cycle pulse after a single-shot frame completes
// Optional feature (macro DSCL_FRAME_STAT_EN):
//   frm_tx_cnt_o   : wrapping count of forwarded frames
//   frm_drop_cnt_o : wrapping count of decimated frames
module pixel_frame_scheduler #(
    parameter int unsigned GS_PXL_W = 8,
    parameter int unsigned COL_NUM  = 640,
    parameter int unsigned ROW_NUM  = 480,
    parameter int unsigned SKIP_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en_i,
    input  logic                     cfg_single_i,
    input  logic [SKIP_W-1:0]        cfg_skip_i,
    pixel_frame_scheduler_if.slave   bus,
    output logic                     busy_o,
`ifdef DSCL_FRAME_STAT_EN
    output logic [15:0]              frm_tx_cnt_o,
    output logic [15:0]              frm_drop_cnt_o,
`endif
    output logic                     done_o
);

    localparam int unsigned OCOL = COL_NUM / 2;
    localparam int unsigned OROW = ROW_NUM / 2;
    localparam int unsigned CW   = (OCOL > 1) ? $clog2(OCOL) : 1;
    localparam int unsigned RW   = (OROW > 1) ? $clog2(OROW) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrop   = 2'd2,
        StDone   = 2'd3
    } state_e;

    state_e            state_q;
    logic [SKIP_W-1:0] skip_q;
    logic              done_q;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;

    logic                stream;
    logic                hs;
    logic                col_last;
    logic                row_last;
    logic                fb;
    logic [GS_PXL_W-1:0] pxl;

    // Data path: zero-latency passthrough, gated only by state.
    assign stream             = (state_q == StStream);
    assign pxl                = bus.pds_pxl;
    assign bus.pat_pxl        = pxl;
    assign bus.pat_pxl_vld    = stream & bus.pds_pxl_vld;
    // Outside STREAM pixels are accepted and discarded so the camera never stalls.
    assign bus.pds_pxl_rdy    = stream ? bus.pat_pxl_rdy : 1'b1;
    assign col_last           = (col_q == CW'(OCOL - 1));
    assign row_last           = (row_q == RW'(OROW - 1));
    assign bus.pat_line_last  = bus.pat_pxl_vld & col_last;
    assign bus.pat_frame_last = bus.pat_line_last & row_last;
    assign busy_o             = stream;
    assign done_o             = done_q;

    // Raster position advances on every accepted pixel, whatever the state.
    assign hs = bus.pds_pxl_vld & bus.pds_pxl_rdy;
    assign fb = hs & col_last & row_last;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (hs) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Frame decisions are taken only at the frame boundary (DONE exit excepted).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            skip_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fb && cfg_en_i) begin
                        state_q <= StStream;
                        skip_q  <= cfg_skip_i;
                    end
                end
                StStream: begin
                    if (fb) begin
                        if (cfg_single_i) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (!cfg_en_i) begin
                            state_q <= StIdle;
                        end else if (skip_q == '0) begin
                            skip_q <= cfg_skip_i;
                        end else begin
                            state_q <= StDrop;
                            skip_q  <= skip_q - 1'b1;
                        end
                    end
                end
                StDrop: begin
                    if (fb) begin
                        if (!cfg_en_i) begin
                            state_q <= StIdle;
                        end else if (skip_q == '0) begin
                            state_q <= StStream;
                            skip_q  <= cfg_skip_i;
                        end else begin
                            skip_q <= skip_q - 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (!cfg_en_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DSCL_FRAME_STAT_EN
    logic [15:0] frm_tx_q;
    logic [15:0] frm_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_tx_q   <= '0;
            frm_drop_q <= '0;
        end else begin
            if (fb && (state_q == StStream)) frm_tx_q <= frm_tx_q + 16'd1;
            if (fb && (state_q == StDrop))   frm_drop_q <= frm_drop_q + 16'd1;
        end
    end

    assign frm_tx_cnt_o   = frm_tx_q;
    assign frm_drop_cnt_o = frm_drop_q;
`endif

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Table-driven bench: 8x4 input raster -> 4x2 output raster, 8 pixels per frame.
module tb_pixel_frame_scheduler;

    localparam int unsigned PW = 8;

    typedef struct {
        bit         rst;
        bit         en;
        bit         single;
        logic [3:0] skip;
        bit         vld;
        bit         rdy;
        logic [7:0] pix;
        bit         e_vld;
        bit         e_rdy;
        bit         e_ll;
        bit         e_fl;
        bit         e_busy;
        bit         e_done;
        bit         chk_stat;
        int         e_tx;
        int         e_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cfg_single = 1'b0;
    logic [3:0] cfg_skip = '0;
    logic       busy;
    logic       done;
`ifdef DSCL_FRAME_STAT_EN
    logic [15:0] tx_cnt;
    logic [15:0] drop_cnt;
`endif

    pixel_frame_scheduler_if #(.GS_PXL_W(PW)) bus ();

    pixel_frame_scheduler #(
        .GS_PXL_W (PW),
        .COL_NUM  (8),
        .ROW_NUM  (4),
        .SKIP_W   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_en_i       (cfg_en),
        .cfg_single_i   (cfg_single),
        .cfg_skip_i     (cfg_skip),
        .bus            (bus),
        .busy_o         (busy),
`ifdef DSCL_FRAME_STAT_EN
        .frm_tx_cnt_o   (tx_cnt),
        .frm_drop_cnt_o (drop_cnt),
`endif
        .done_o         (done)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add_rst();
        vec_t v;
        v = '{default: 0};
        v.rst = 1'b1;
        v.vld = 1'b1;
        v.rdy = 1'b1;
        v.pix = 8'hA5;
        v.e_rdy = 1'b1;
        tbl.push_back(v);
    endtask

    // One accepted pixel at raster position p (counted from the last reset).
    task automatic add_px(input int p, input bit strm, input bit en, input bit single,
                          input logic [3:0] skip, input bit dn);
        vec_t v;
        v = '{default: 0};
        v.en = en;
        v.single = single;
        v.skip = skip;
        v.vld = 1'b1;
        v.rdy = 1'b1;
        v.pix = p[7:0];
        v.e_vld = strm;
        v.e_rdy = 1'b1;
        v.e_ll = strm && (p % 4 == 3);
        v.e_fl = strm && (p % 8 == 7);
        v.e_busy = strm;
        v.e_done = dn;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        int   fr;

        // Run 1: continuous, skip=0; frame 0 discarded; two idle gaps mid-frame.
        add_rst();
        for (int p = 0; p < 24; p++) begin
            add_px(p, p >= 8, 1'b1, 1'b0, 4'd0, 1'b0);
            if (p == 12) begin
                for (int g = 0; g < 2; g++) begin
                    v = '{default: 0};
                    v.en = 1'b1;
                    v.rdy = 1'b1;
                    v.pix = 8'hEE;
                    v.e_rdy = 1'b1;
                    v.e_busy = 1'b1;
                    tbl.push_back(v);
                end
            end
        end

        // Run 2: skip=2 -> frames 1,4,7 forwarded, others discarded.
        add_rst();
        for (int p = 0; p < 72; p++) begin
            fr = p / 8;
            add_px(p, (fr == 1) || (fr == 4) || (fr == 7), 1'b1, 1'b0, 4'd2, 1'b0);
            if (p == 56) begin
                tbl[$].chk_stat = 1'b1;
                tbl[$].e_tx = 2;
                tbl[$].e_drop = 4;
            end
        end

        // Run 3: single-shot; en low one cycle in DONE re-arms for the next frame.
        add_rst();
        for (int p = 0; p < 40; p++) begin
            fr = p / 8;
            add_px(p, (fr == 1) || (fr == 3), p != 20, 1'b1, 4'd0, (p == 16) || (p == 32));
        end

        // Run 4: en dropped at the 3rd pixel of a streamed frame; frame still completes.
        add_rst();
        for (int p = 0; p < 24; p++) begin
            add_px(p, p / 8 == 1, p < 10, 1'b0, 4'd0, 1'b0);
        end

        // Run 5: downstream back-pressure for 5 cycles at pixel 10.
        add_rst();
        for (int p = 0; p < 10; p++) add_px(p, p >= 8, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            v = '{default: 0};
            v.en = 1'b1;
            v.vld = 1'b1;
            v.pix = 8'd10;
            v.e_vld = 1'b1;
            v.e_busy = 1'b1;
            tbl.push_back(v);
        end
        for (int p = 10; p < 20; p++) add_px(p, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Run 6: reset at the 5th pixel of a streamed frame, then a fresh discarded frame.
        add_rst();
        for (int p = 0; p < 12; p++) add_px(p, p >= 8, 1'b1, 1'b0, 4'd0, 1'b0);
        add_rst();
        for (int p = 0; p < 16; p++) add_px(p, p >= 8, 1'b1, 1'b0, 4'd0, 1'b0);

        // Apply: drive 1 time unit after the rising edge, check on the falling edge.
        bus.pds_pxl = '0;
        bus.pds_pxl_vld = 1'b0;
        bus.pat_pxl_rdy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(posedge clk);
            #1;
            rst_n = v.rst ? 1'b0 : 1'b1;
            cfg_en = v.en;
            cfg_single = v.single;
            cfg_skip = v.skip;
            bus.pds_pxl = v.pix;
            bus.pds_pxl_vld = v.vld;
            bus.pat_pxl_rdy = v.rdy;
            @(negedge clk);
            check("pat_pxl", i, 32'(bus.pat_pxl), 32'(v.pix));
            check("pat_pxl_vld", i, 32'(bus.pat_pxl_vld), 32'(v.e_vld));
            check("pds_pxl_rdy", i, 32'(bus.pds_pxl_rdy), 32'(v.e_rdy));
            check("line_last", i, 32'(bus.pat_line_last), 32'(v.e_ll));
            check("frame_last", i, 32'(bus.pat_frame_last), 32'(v.e_fl));
            check("busy", i, 32'(busy), 32'(v.e_busy));
            check("done", i, 32'(done), 32'(v.e_done));
`ifdef DSCL_FRAME_STAT_EN
            if (v.chk_stat) begin
                check("frm_tx_cnt", i, 32'(tx_cnt), 32'(v.e_tx));
                check("frm_drop_cnt", i, 32'(drop_cnt), 32'(v.e_drop));
            end
`endif
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
